// File: rtl/decode_stage.sv
// decode_stage: second stage of the 16-bit core.
//
// Holds the IF/ID latch, decodes the instruction in it, and reads the 8x16
// register file. Branches and jumps are resolved here. A 2-bit per-register
// scoreboard plus the load-use rule decide when decode must interlock. The
// decoded instruction goes out as a registered ID/EX bundle.
//
// Optional feature macro: DECODE_WB_BYPASS_EN
//   defined   - register reads see a same-cycle writeback (write-through), and
//               a BEQZ whose producer is retiring this cycle may proceed.
//   undefined - reads return the stored value; a source that matches the
//               writeback register costs one interlock cycle instead.
//
// Ports:
//   clk, reset                      rising-edge clock, synchronous active-low reset
//   inst_code_high/low              instruction bits [15:8] / [7:0] from fetch
//   if_pc                           address of the instruction fetch presents
//   stall_in                        downstream freeze request
//   wb_we, wb_rd, wb_data           register-file write port from writeback
//   sel_pc                          fetch PC source: 00 init, 01 PC+2, 10 branch_pc
//   branch_pc, enable_pc            branch target and fetch PC register enable
//   ex_valid/we/mem_read/mem_write/illegal, ex_op/func/rd/ra/rb, ex_a/b/imm
//                                   registered ID/EX bundle for execute
module decode_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  inst_code_high,
    input  logic [7:0]  inst_code_low,
    input  logic [15:0] if_pc,
    input  logic        stall_in,
    input  logic        wb_we,
    input  logic [2:0]  wb_rd,
    input  logic [15:0] wb_data,
    output logic [1:0]  sel_pc,
    output logic [15:0] branch_pc,
    output logic        enable_pc,
    output logic        ex_valid,
    output logic        ex_we,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_illegal,
    output logic [3:0]  ex_op,
    output logic [2:0]  ex_func,
    output logic [2:0]  ex_rd,
    output logic [2:0]  ex_ra,
    output logic [2:0]  ex_rb,
    output logic [15:0] ex_a,
    output logic [15:0] ex_b,
    output logic [15:0] ex_imm
);

    localparam logic [3:0] OP_ALU   = 4'd1;
    localparam logic [3:0] OP_ADDI  = 4'd2;
    localparam logic [3:0] OP_LOAD  = 4'd3;
    localparam logic [3:0] OP_STORE = 4'd4;
    localparam logic [3:0] OP_BEQZ  = 4'd5;
    localparam logic [3:0] OP_JMP   = 4'd6;

    typedef struct packed {
        logic        valid;
        logic        we;
        logic        mem_read;
        logic        mem_write;
        logic        illegal;
        logic [3:0]  op;
        logic [2:0]  func;
        logic [2:0]  rd;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] imm;
    } idex_t;

    typedef enum logic [2:0] {
        ACT_RESET,
        ACT_STALL,
        ACT_HOLD,
        ACT_BRANCH,
        ACT_SEQ
    } action_t;

    logic        ifid_valid;
    logic [15:0] ifid_inst;
    logic [15:0] ifid_pc;
    logic [15:0] rf     [8];
    logic [1:0]  sb_cnt [8];
    idex_t       ex_q;

    logic [3:0]  dec_op;
    logic [2:0]  dec_rd;
    logic [2:0]  dec_ra;
    logic [2:0]  dec_rb;
    logic [2:0]  b_sel;
    logic        uses_a;
    logic        uses_b;
    logic        writes;
    logic        is_branch;
    logic [15:0] rd_a;
    logic [15:0] rd_b;
    logic        load_use;
    logic        beqz_wait;
    logic        saturated;
    logic        wb_hazard;
    logic        interlock;
    logic        taken;
    logic [15:0] offset;
    logic [15:0] target;
    action_t     action;
    idex_t       issue;
    logic [7:0]  sb_inc;
    logic [7:0]  sb_dec;

    assign dec_op = ifid_inst[15:12];
    assign dec_rd = ifid_inst[11:9];
    assign dec_ra = ifid_inst[8:6];
    assign dec_rb = ifid_inst[5:3];

    // STORE data and the BEQZ test both come from the [11:9] field, so port B
    // is steered there; the BEQZ test value is simply rd_b.
    assign b_sel     = (dec_op == OP_STORE || dec_op == OP_BEQZ) ? dec_rd : dec_rb;
    assign uses_a    = (dec_op == OP_ALU) || (dec_op == OP_ADDI) ||
                       (dec_op == OP_LOAD) || (dec_op == OP_STORE);
    assign uses_b    = (dec_op == OP_ALU) || (dec_op == OP_STORE) || (dec_op == OP_BEQZ);
    assign writes    = (dec_op == OP_ALU) || (dec_op == OP_ADDI) || (dec_op == OP_LOAD);
    assign is_branch = (dec_op == OP_BEQZ) || (dec_op == OP_JMP);

    always_comb begin
        rd_a = rf[dec_ra];
        rd_b = rf[b_sel];
`ifdef DECODE_WB_BYPASS_EN
        if (wb_we && wb_rd == dec_ra) rd_a = wb_data;
        if (wb_we && wb_rd == b_sel)  rd_b = wb_data;
`endif
    end

    always_comb begin
        load_use = ex_q.valid && ex_q.mem_read &&
                   ((uses_a && ex_q.rd == dec_ra) || (uses_b && ex_q.rd == b_sel));
        beqz_wait = (dec_op == OP_BEQZ) && (sb_cnt[dec_rd] != 2'd0);
        saturated = writes && (sb_cnt[dec_rd] == 2'd3);
`ifdef DECODE_WB_BYPASS_EN
        // The last outstanding write is retiring now and rd_b already sees it.
        if (sb_cnt[dec_rd] == 2'd1 && wb_we && wb_rd == dec_rd) beqz_wait = 1'b0;
        wb_hazard = 1'b0;
`else
        wb_hazard = wb_we && ((uses_a && wb_rd == dec_ra) || (uses_b && wb_rd == b_sel));
`endif
        interlock = ifid_valid && (load_use || beqz_wait || saturated || wb_hazard);
    end

    assign taken  = ifid_valid && ((dec_op == OP_JMP) ||
                                   (dec_op == OP_BEQZ && rd_b == 16'd0));
    assign offset = (dec_op == OP_JMP) ? {{3{ifid_inst[11]}}, ifid_inst[11:0], 1'b0}
                                       : {{6{ifid_inst[8]}}, ifid_inst[8:0], 1'b0};
    assign target = ifid_pc + 16'd2 + offset;

    always_comb begin
        if (!reset)         action = ACT_RESET;
        else if (stall_in)  action = ACT_STALL;
        else if (interlock) action = ACT_HOLD;
        else if (taken)     action = ACT_BRANCH;
        else                action = ACT_SEQ;
    end

    always_comb begin
        sel_pc    = 2'b01;
        enable_pc = 1'b1;
        case (action)
            ACT_RESET:  sel_pc = 2'b00;
            ACT_STALL:  enable_pc = 1'b0;
            ACT_HOLD:   enable_pc = 1'b0;
            ACT_BRANCH: sel_pc = 2'b10;
            default:    ;
        endcase
        branch_pc = (reset && ifid_valid && is_branch) ? target : 16'd0;
    end

    always_comb begin
        issue       = '0;
        issue.valid = 1'b1;
        issue.func  = ifid_inst[2:0];
        issue.rd    = dec_rd;
        issue.ra    = dec_ra;
        issue.rb    = dec_rb;
        issue.a     = rd_a;
        issue.b     = rd_b;
        issue.imm   = {{10{ifid_inst[5]}}, ifid_inst[5:0]};
        if (dec_op <= OP_JMP) begin
            issue.op        = dec_op;
            issue.we        = writes;
            issue.mem_read  = (dec_op == OP_LOAD);
            issue.mem_write = (dec_op == OP_STORE);
        end else begin
            // Unassigned opcodes travel as a NOP flagged illegal.
            issue.illegal = 1'b1;
        end
    end

    always_comb begin
        sb_inc = '0;
        sb_dec = '0;
        if (action == ACT_SEQ && ifid_valid && writes) sb_inc[dec_rd] = 1'b1;
        if (wb_we) sb_dec[wb_rd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ifid_valid <= 1'b0;
            ifid_inst  <= '0;
            ifid_pc    <= '0;
            ex_q       <= '0;
            for (int i = 0; i < 8; i++) begin
                rf[i]     <= '0;
                sb_cnt[i] <= '0;
            end
        end else begin
            // Writeback and scoreboard retirement proceed even while frozen.
            if (wb_we) rf[wb_rd] <= wb_data;
            for (int i = 0; i < 8; i++) begin
                if (sb_inc[i] && !sb_dec[i])
                    sb_cnt[i] <= sb_cnt[i] + 2'd1;
                else if (sb_dec[i] && !sb_inc[i] && sb_cnt[i] != 2'd0)
                    sb_cnt[i] <= sb_cnt[i] - 2'd1;
            end
            case (action)
                ACT_HOLD: ex_q <= '0;
                ACT_BRANCH: begin
                    ifid_valid <= 1'b0;
                    ex_q       <= '0;
                end
                ACT_SEQ: begin
                    ifid_valid <= 1'b1;
                    ifid_inst  <= {inst_code_high, inst_code_low};
                    ifid_pc    <= if_pc;
                    ex_q       <= ifid_valid ? issue : '0;
                end
                default: ;
            endcase
        end
    end

    assign ex_valid     = ex_q.valid;
    assign ex_we        = ex_q.we;
    assign ex_mem_read  = ex_q.mem_read;
    assign ex_mem_write = ex_q.mem_write;
    assign ex_illegal   = ex_q.illegal;
    assign ex_op        = ex_q.op;
    assign ex_func      = ex_q.func;
    assign ex_rd        = ex_q.rd;
    assign ex_ra        = ex_q.ra;
    assign ex_rb        = ex_q.rb;
    assign ex_a         = ex_q.a;
    assign ex_b         = ex_q.b;
    assign ex_imm       = ex_q.imm;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

`ifdef DECODE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  inst_code_high = '0;
    logic [7:0]  inst_code_low = '0;
    logic [15:0] if_pc = '0;
    logic        stall_in = 1'b0;
    logic        wb_we = 1'b0;
    logic [2:0]  wb_rd = '0;
    logic [15:0] wb_data = '0;
    logic [1:0]  sel_pc;
    logic [15:0] branch_pc;
    logic        enable_pc;
    logic        ex_valid, ex_we, ex_mem_read, ex_mem_write, ex_illegal;
    logic [3:0]  ex_op;
    logic [2:0]  ex_func, ex_rd, ex_ra, ex_rb;
    logic [15:0] ex_a, ex_b, ex_imm;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .reset(reset),
        .inst_code_high(inst_code_high), .inst_code_low(inst_code_low),
        .if_pc(if_pc), .stall_in(stall_in),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .sel_pc(sel_pc), .branch_pc(branch_pc), .enable_pc(enable_pc),
        .ex_valid(ex_valid), .ex_we(ex_we), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_illegal(ex_illegal),
        .ex_op(ex_op), .ex_func(ex_func), .ex_rd(ex_rd), .ex_ra(ex_ra), .ex_rb(ex_rb),
        .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm)
    );

    typedef struct packed {
        logic        valid, we, mr, mw, ill;
        logic [3:0]  op;
        logic [2:0]  func, rd, ra, rb;
        logic [15:0] a, b, imm;
    } ex_t;

    int checks = 0;
    int errors = 0;

    // Reference model: architectural state of the stage.
    bit          m_known = 1'b0;
    logic [15:0] m_reg [8] = '{default: 16'd0};
    int          m_cnt [8] = '{default: 0};
    bit          m_v = 1'b0;
    logic [15:0] m_w = '0;
    logic [15:0] m_pc = '0;
    ex_t         m_ex = '0;

    // Next-state and expected combinational outputs for the current cycle.
    logic [15:0] n_reg [8];
    int          n_cnt [8];
    bit          n_v;
    logic [15:0] n_w, n_pc;
    ex_t         n_ex;
    logic [1:0]  e_sel;
    logic        e_en;
    logic [15:0] e_bpc;

    // Current inputs as driven.
    logic        c_rst, c_st, c_we;
    logic [2:0]  c_wrd;
    logic [15:0] c_wd, c_inst, c_pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] mread(input int r);
        if (BYP && c_we && int'(c_wrd) == r) return c_wd;
        return m_reg[r];
    endfunction

    task automatic model_comb();
        int  op, rd, ra, rb, o, c;
        int  srcs[$];
        bit  wr, haz, tk;
        ex_t is;
        op = int'(m_w[15:12]);
        rd = int'(m_w[11:9]);
        ra = int'(m_w[8:6]);
        rb = int'(m_w[5:3]);
        if (op >= 1 && op <= 4) srcs.push_back(ra);
        if (op == 1) srcs.push_back(rb);
        if (op == 4 || op == 5) srcs.push_back(rd);
        wr  = (op >= 1 && op <= 3);
        haz = 1'b0;
        foreach (srcs[i]) begin
            if (m_ex.valid && m_ex.mr && int'(m_ex.rd) == srcs[i]) haz = 1'b1;
            if (!BYP && c_we && int'(c_wrd) == srcs[i]) haz = 1'b1;
        end
        if (op == 5) begin
            c = m_cnt[rd];
            if (BYP && c == 1 && c_we && int'(c_wrd) == rd) c = 0;
            if (c != 0) haz = 1'b1;
        end
        if (wr && m_cnt[rd] == 3) haz = 1'b1;
        haz = haz && m_v;
        tk  = m_v && (op == 6 || (op == 5 && mread(rd) == 16'd0));
        if (op == 6) begin
            o = int'(m_w[11:0]);
            if (o >= 2048) o -= 4096;
        end else begin
            o = int'(m_w[8:0]);
            if (o >= 256) o -= 512;
        end

        is       = '0;
        is.valid = 1'b1;
        is.func  = m_w[2:0];
        is.rd    = m_w[11:9];
        is.ra    = m_w[8:6];
        is.rb    = m_w[5:3];
        is.a     = mread(ra);
        is.b     = mread((op == 4 || op == 5) ? rd : rb);
        is.imm   = 16'(int'(m_w[5:0]) - ((m_w[5]) ? 64 : 0));
        if (op <= 6) begin
            is.op = 4'(op);
            is.we = wr;
            is.mr = (op == 3);
            is.mw = (op == 4);
        end else begin
            is.ill = 1'b1;
        end

        n_reg = m_reg;
        n_cnt = m_cnt;
        n_v = m_v; n_w = m_w; n_pc = m_pc; n_ex = m_ex;
        e_bpc = '0; e_sel = 2'b01; e_en = 1'b1;
        if (!c_rst) begin
            e_sel = 2'b00;
            foreach (n_reg[i]) begin n_reg[i] = '0; n_cnt[i] = 0; end
            n_v = 0; n_w = '0; n_pc = '0; n_ex = '0;
        end else begin
            if (m_v && (op == 5 || op == 6)) e_bpc = 16'(int'(m_pc) + 2 + 2 * o);
            if (c_we) n_reg[c_wrd] = c_wd;
            if (c_st) begin
                e_en = 1'b0;
            end else if (haz) begin
                e_en = 1'b0;
                n_ex = '0;
            end else if (tk) begin
                e_sel = 2'b10;
                n_v = 0;
                n_ex = '0;
            end else begin
                n_v = 1; n_w = c_inst; n_pc = c_pc;
                n_ex = m_v ? is : '0;
            end
            for (int r = 0; r < 8; r++) begin
                bit inc, dec;
                inc = !c_st && !haz && !tk && m_v && wr && rd == r;
                dec = c_we && int'(c_wrd) == r;
                if (inc && !dec) n_cnt[r] = m_cnt[r] + 1;
                else if (dec && !inc && m_cnt[r] > 0) n_cnt[r] = m_cnt[r] - 1;
            end
        end
    endtask

    task automatic compare_all();
        chk("sel_pc", sel_pc, e_sel);
        chk("enable_pc", enable_pc, e_en);
        chk("branch_pc", branch_pc, e_bpc);
        chk("ex_valid", ex_valid, m_ex.valid);
        chk("ex_we", ex_we, m_ex.we);
        chk("ex_mem_read", ex_mem_read, m_ex.mr);
        chk("ex_mem_write", ex_mem_write, m_ex.mw);
        chk("ex_illegal", ex_illegal, m_ex.ill);
        chk("ex_op", ex_op, m_ex.op);
        chk("ex_func", ex_func, m_ex.func);
        chk("ex_rd", ex_rd, m_ex.rd);
        chk("ex_ra", ex_ra, m_ex.ra);
        chk("ex_rb", ex_rb, m_ex.rb);
        chk("ex_a", ex_a, m_ex.a);
        chk("ex_b", ex_b, m_ex.b);
        chk("ex_imm", ex_imm, m_ex.imm);
    endtask

    task automatic drive(input logic [15:0] inst, input logic [15:0] pc,
                         input logic st = 1'b0, input logic we = 1'b0,
                         input logic [2:0] wrd = 3'd0, input logic [15:0] wd = 16'd0,
                         input logic rst = 1'b1);
        @(negedge clk);
        reset = rst; {inst_code_high, inst_code_low} = inst; if_pc = pc;
        stall_in = st; wb_we = we; wb_rd = wrd; wb_data = wd;
        c_rst = rst; c_inst = inst; c_pc = pc; c_st = st; c_we = we; c_wrd = wrd; c_wd = wd;
        #1;
        model_comb();
        if (m_known) compare_all();
    endtask

    task automatic tick();
        @(posedge clk);
        m_reg = n_reg; m_cnt = n_cnt; m_v = n_v; m_w = n_w; m_pc = n_pc; m_ex = n_ex;
        if (!c_rst) m_known = 1'b1;
    endtask

    task automatic step(input logic [15:0] inst, input logic [15:0] pc,
                        input logic st = 1'b0, input logic we = 1'b0,
                        input logic [2:0] wrd = 3'd0, input logic [15:0] wd = 16'd0);
        drive(inst, pc, st, we, wrd, wd);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: no finish by %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int  waited;
        bit  seen;

        // Reset, then ADDI r1, r0, 5
        drive(16'h0000, 16'h0000, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0); tick();
        drive(16'h0000, 16'h0000, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0);
        chk("rst_sel", sel_pc, 2'b00);
        chk("rst_en", enable_pc, 1'b1);
        chk("rst_bpc", branch_pc, 16'h0000);
        chk("rst_exv", ex_valid, 1'b0);
        tick();
        drive(16'h2205, 16'h0000);
        chk("rel_sel", sel_pc, 2'b01);
        tick();
        step(16'h0000, 16'h0002);
        drive(16'h0000, 16'h0004);
        chk("addi_v", ex_valid, 1'b1);
        chk("addi_op", ex_op, 4'd2);
        chk("addi_rd", ex_rd, 3'd1);
        chk("addi_imm", ex_imm, 16'h0005);
        chk("addi_we", ex_we, 1'b1);
        tick();

        // Load-use: LOAD r2 then ALU r3 = r2 op r1
        step(16'h3440, 16'h0006);
        step(16'h1688, 16'h0008);
        drive(16'h0000, 16'h000A);
        chk("lu_en", enable_pc, 1'b0);
        tick();
        drive(16'h0000, 16'h000A);
        chk("lu_bub", ex_valid, 1'b0);
        tick();
        drive(16'h0000, 16'h000C);
        chk("lu_ra", ex_ra, 3'd2);
        chk("lu_op", ex_op, 4'd1);
        tick();

        // JMP -1 at 0x0010
        step(16'h6FFF, 16'h0010);
        drive(16'h0000, 16'h0012);
        chk("jmp_sel", sel_pc, 2'b10);
        chk("jmp_bpc", branch_pc, 16'h0010);
        chk("jmp_en", enable_pc, 1'b1);
        tick();
        drive(16'h0000, 16'h0010);
        chk("jmp_bub1", ex_valid, 1'b0);
        tick();
        drive(16'h0000, 16'h0012);
        chk("jmp_bub2", ex_valid, 1'b0);
        tick();
        drive(16'h0000, 16'h0014);
        chk("jmp_resume", ex_valid, 1'b1);
        tick();

        // BEQZ r4, +3 at 0xFFFE: taken with wrap, then not taken with r4 = 7
        step(16'h5803, 16'hFFFE);
        drive(16'h0000, 16'h0000);
        chk("bz_bpc", branch_pc, 16'h0006);
        chk("bz_sel", sel_pc, 2'b10);
        tick();
        step(16'h0000, 16'h0006);
        step(16'h0000, 16'h0008, 1'b0, 1'b1, 3'd4, 16'h0007);
        step(16'h5803, 16'hFFFE);
        drive(16'h0000, 16'h0000);
        chk("bz_nt_sel", sel_pc, 2'b01);
        chk("bz_nt_en", enable_pc, 1'b1);
        tick();
        step(16'h0000, 16'h0002);

        // Same-cycle writeback of r5 read by ADDI r6, r5, 0
        step(16'h2D40, 16'h0020);
        drive(16'h0000, 16'h0022, 1'b0, 1'b1, 3'd5, 16'h1234);
        chk("wb_en", enable_pc, BYP ? 1'b1 : 1'b0);
        tick();
        waited = -1;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(16'h0000, 16'h0024);
            if (!seen && ex_valid && ex_op == 4'd2 && ex_rd == 3'd6) begin
                seen = 1'b1;
                waited = k;
                chk("wb_a", ex_a, 16'h1234);
            end
            tick();
        end
        chk("wb_seen", seen, 1'b1);
        chk("wb_lat", waited, BYP ? 0 : 1);

        // stall_in for 3 cycles while ALU r0 = r1 op r2 waits to issue
        step(16'h1053, 16'h0030);
        for (int k = 0; k < 3; k++) begin
            drive(16'h0000, 16'h0032, 1'b1);
            chk("st_en", enable_pc, 1'b0);
            chk("st_op", ex_op, 4'd0);
            chk("st_v", ex_valid, 1'b1);
            tick();
        end
        drive(16'h0000, 16'h0032);
        chk("st_rel_en", enable_pc, 1'b1);
        tick();
        drive(16'h0000, 16'h0034);
        chk("st_issue_op", ex_op, 4'd1);
        chk("st_issue_func", ex_func, 3'd3);
        tick();

        // Scoreboard saturation: four ADDI r7, r0, 1
        step(16'h2E01, 16'h0040);
        step(16'h2E01, 16'h0042);
        step(16'h2E01, 16'h0044);
        step(16'h2E01, 16'h0046);
        drive(16'h0000, 16'h0048);
        chk("sat_en", enable_pc, 1'b0);
        tick();
        drive(16'h0000, 16'h0048, 1'b0, 1'b1, 3'd7, 16'h00AA);
        chk("sat_en2", enable_pc, 1'b0);
        tick();
        drive(16'h0000, 16'h0048);
        chk("sat_go", enable_pc, 1'b1);
        tick();
        drive(16'h0000, 16'h004A);
        chk("sat_rd", ex_rd, 3'd7);
        tick();

        // Illegal opcode, STORE, then reset in the middle of a stall
        step(16'hA123, 16'h0050);
        step(16'h4A50, 16'h0052);
        drive(16'h0000, 16'h0054);
        chk("ill_flag", ex_illegal, 1'b1);
        tick();
        step(16'h0000, 16'h0056, 1'b1);
        drive(16'h0000, 16'h0056, 1'b1, 1'b0, 3'd0, 16'd0, 1'b0);
        chk("mid_rst_sel", sel_pc, 2'b00);
        chk("mid_rst_en", enable_pc, 1'b1);
        tick();
        drive(16'h0000, 16'h0000);
        chk("post_rst_v", ex_valid, 1'b0);
        chk("post_rst_sel", sel_pc, 2'b01);
        tick();
        step(16'h0000, 16'h0002);
        step(16'h0000, 16'h0004);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Second pipeline stage of the 16-bit core. Captures the 16-bit instruction word `{inst_code_high, inst_code_low}` presented by fetch into an IF/ID latch. It decodes the word, reads an 8×16 register file and resolves branches/jumps locally. It also interlocks on hazards, drives fetch's `sel_pc`/`branch_pc`/`enable_pc`, and issues a registered ID/EX bundle to execute.

## Interface
- No parameters. Data width 16, 8 registers (r0–r7, r0 writable), instruction 16 bits.
- Clock and reset: one clock; reset is synchronous and active-low.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-low.
- `inst_code_high` / `inst_code_low` in 8 each: instruction bits [15:8] / [7:0] from fetch.
- `if_pc` in 16: address of the instruction currently presented by fetch.
- `stall_in` in 1: downstream freeze request.
- `wb_we` in 1, `wb_rd` in 3, `wb_data` in 16: register-file write port from writeback.
- `sel_pc` out 2: fetch PC source. 00 = initial address, 01 = PC+2, 10 = `branch_pc`.
- `branch_pc` out 16: branch/jump target.
- `enable_pc` out 1: fetch PC register enable.
- `ex_valid`, `ex_we`, `ex_mem_read`, `ex_mem_write`, `ex_illegal` out 1 each: registered controls.
- `ex_op` out 4, `ex_func` out 3, `ex_rd` / `ex_ra` / `ex_rb` out 3 each: registered fields.
- `ex_a`, `ex_b`, `ex_imm` out 16 each: operand A, operand B, sign-extended immediate.

## Operation
- Fields: op = [15:12], rd = [11:9], ra = [8:6], rb = [5:3], func = [2:0], imm6 = [5:0], off9 = [8:0], off12 = [11:0].
- Opcode behaviour (A reads ra, B reads rb unless stated):
  - 0 NOP.
  - 1 ALU: writes rd.
  - 2 ADDI: writes rd, imm = sext(imm6).
  - 3 LOAD: writes rd, mem_read.
  - 4 STORE: B reads [11:9], mem_write.
  - 5 BEQZ: tests r[[11:9]].
  - 6 JMP.
  - 7–15: issued as NOP with `ex_illegal` = 1.
- Branch target is `id_pc + 2 + (sext(offset) << 1)`, computed modulo 2^16 (wraps). BEQZ is taken when the register value is 0; JMP is always taken.
- Scoreboard: one 2-bit counter per register.
  - The counter increments when a writing instruction issues into ID/EX and decrements on `wb_we` to that register. Simultaneous increment and decrement leaves it unchanged.
  - A decrement at 0 is ignored.
- Interlocks (IF/ID holds, `enable_pc` = 0, ID/EX receives a bubble):
  - Load-use: the current ID/EX entry is a LOAD and its rd equals a source register used by the decoded instruction.
  - BEQZ test: the tested register has a nonzero counter.
  - Saturation: a writing instruction whose rd counter is 3.
- Priority, highest first: reset > `stall_in` > interlock > taken branch > sequential.
- `stall_in` = 1: IF/ID and ID/EX hold, `enable_pc` = 0, no counter increments. Writeback decrements and writes still apply.
- Taken branch: `sel_pc` = 10, `enable_pc` = 1. At the edge, IF/ID loads a bubble (squashes the PC+2 instruction). The branch itself issues as a bubble (`ex_valid` = 0).
- Sequential: `sel_pc` = 01, `enable_pc` = 1, and IF/ID captures fetch output with `if_pc`.
- ALU/ALU forwarding belongs to execute; this block exports `ex_ra`/`ex_rb` for it.

## Timing
- Reset (`reset` = 0 at an edge):
  - `sel_pc` = 00 and `enable_pc` = 1, so fetch's PC loads the initial address.
  - IF/ID is invalid; every `ex_*` output is 0; all counters and all registers are 0.
  - `branch_pc` = 0.
- First cycle after release: `sel_pc` = 01, and IF/ID captures the instruction at the initial address.
- Latency: an instruction presented by fetch in cycle n is in IF/ID during n+1 and on `ex_*` during n+2.
- `sel_pc`, `branch_pc` and `enable_pc` are combinational from IF/ID contents and the register file. They are valid in the same cycle as decode.
- Taken-branch penalty: 1 bubble. Load-use penalty: 1 cycle. BEQZ waits until the producer's writeback.
- Register-file reads are combinational; writes occur at the clock edge.
- Reset asserted mid-stall or mid-branch: reset wins, and all pending state is cleared.

## Configuration
- `DECODE_WB_BYPASS_EN` defined:
  - A read of register `wb_rd` while `wb_we` = 1 returns `wb_data` in the same cycle (write-through).
  - The BEQZ test treats a counter of 1 that is being decremented this cycle as clear.
- Undefined:
  - Reads return the old value.
  - Any source register equal to `wb_rd` with `wb_we` = 1 causes a 1-cycle interlock.

## Test plan
- Reset, then release with fetch presenting 0x2205 (ADDI r1, r0, 5) → during reset `sel_pc` = 00. Two cycles after release: `ex_valid` = 1, `ex_op` = 2, `ex_rd` = 1, `ex_imm` = 0x0005, `ex_we` = 1.
- LOAD r2 (0x3440) followed by ALU r3 = r2 op r1 (0x1688) → one cycle with `enable_pc` = 0 and `ex_valid` = 0. The ALU then issues with `ex_ra` = 2.
- JMP −1 (0x6FFF) at `if_pc` = 0x0010 → `sel_pc` = 10, `branch_pc` = 0x0010. The next IF/ID entry is a bubble and `ex_valid` stays 0 for 2 cycles.
- BEQZ r4, +3 (0x5803) at `if_pc` = 0xFFFE with r4 = 0 and its counter 0 → `branch_pc` = 0x0006 (wrap). With r4 = 7, `sel_pc` = 01.
- Writeback r5 = 0x1234 in the same cycle that decode reads r5 → with the macro, `ex_a` = 0x1234 and there is no stall. Without the macro, a 1-cycle interlock, then `ex_a` = 0x1234.
- `stall_in` = 1 for 3 cycles during an ALU issue → `ex_*` held constant, `enable_pc` = 0, scoreboard unchanged. Issue resumes the cycle after release.
